// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory controller.
// The dma_* signals exist only when MEM_ARB_DMA_EN is defined.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

`ifdef MEM_ARB_DMA_EN
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
`endif

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_is_write;
    logic [31:0] mem_rdata;
    logic        mem_busy;

    modport slave (
`ifdef MEM_ARB_DMA_EN
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
`endif
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        output mem_addr, mem_wdata, mem_is_write,
        input  mem_rdata, mem_busy
    );

    modport master (
`ifdef MEM_ARB_DMA_EN
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
`endif
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  mem_addr, mem_wdata, mem_is_write,
        output mem_rdata, mem_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-memory arbiter for instruction fetch, CPU data and (optionally) DMA.
// Optional DMA port: define MEM_ARB_DMA_EN.
// Priority is data > DMA > fetch; fetch is forced to win once it has lost
// STARVE_LIMIT consecutive arbitrations while requesting.
// Acks are combinational from the FSM state (single cycle, never during rst);
// the read data register of a port updates at the end of its ack cycle, so the
// new value is visible from the cycle after the ack.
//
// state    | meaning
// IDLE     | no access; arbitrate pending requests
// RD_WAIT  | read address held; count down READ_WAIT, then wait for !mem_busy
// WR_PULSE | one-cycle mem_is_write strobe
// WR_WAIT  | wait for the controller to drop mem_busy, then ack the write
module mem_arbiter #(
    parameter int READ_WAIT    = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_PULSE, WR_WAIT} state_t;
    typedef enum logic [1:0] {SRC_FETCH, SRC_DATA, SRC_DMA} src_t;

    localparam logic [3:0] RD_CNT_INIT = 4'(READ_WAIT);
    localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    src_t        src_q, gnt_src;
    logic        gnt_valid, gnt_we;
    logic [31:0] gnt_addr, gnt_wdata;
    logic [3:0]  wait_cnt_q, starve_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic        ack_cycle, is_write;
    logic        grant_now;
`ifdef MEM_ARB_DMA_EN
    logic [31:0] dma_rdata_q;
`endif

    // Pick the winning requester; only acted upon while IDLE.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_FETCH;
        gnt_we    = 1'b0;
        gnt_addr  = bus.if_addr;
        gnt_wdata = '0;
        if (bus.if_req && (starve_q == STARVE_MAX)) begin
            gnt_valid = 1'b1;
        end else if (bus.d_req) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_DATA;
            gnt_we    = bus.d_we;
            gnt_addr  = bus.d_addr;
            gnt_wdata = bus.d_wdata;
        end
`ifdef MEM_ARB_DMA_EN
        else if (bus.dma_req) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_DMA;
            gnt_we    = bus.dma_we;
            gnt_addr  = bus.dma_addr;
            gnt_wdata = bus.dma_wdata;
        end
`endif
        else if (bus.if_req) begin
            gnt_valid = 1'b1;
        end
    end

    assign grant_now = (state_q == IDLE) && gnt_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, write strobe and completion detection.
    always_comb begin
        state_d   = state_q;
        ack_cycle = 1'b0;
        is_write  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) state_d = gnt_we ? WR_PULSE : RD_WAIT;
            end
            RD_WAIT: begin
                if ((wait_cnt_q == 4'd0) && !bus.mem_busy) begin
                    ack_cycle = !rst;
                    state_d   = IDLE;
                end
            end
            WR_PULSE: begin
                is_write = 1'b1;
                state_d  = WR_WAIT;
            end
            WR_WAIT: begin
                if (!bus.mem_busy) begin
                    ack_cycle = !rst;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the granted request and run the read wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= SRC_FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
        end else if (grant_now) begin
            src_q   <= gnt_src;
            addr_q  <= gnt_addr;
            wdata_q <= gnt_wdata;
            if (!gnt_we) wait_cnt_q <= RD_CNT_INIT;
        end else if ((state_q == RD_WAIT) && (wait_cnt_q != 4'd0)) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    // Count consecutive lost arbitrations of a requesting fetch port.
    always_ff @(posedge clk) begin
        if (rst || !bus.if_req) begin
            starve_q <= '0;
        end else if (grant_now) begin
            if (gnt_src == SRC_FETCH)      starve_q <= '0;
            else if (starve_q != STARVE_MAX) starve_q <= starve_q + 4'd1;
        end
    end

    // Capture read data into the owning port at its ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_DMA_EN
            dma_rdata_q <= '0;
`endif
        end else if (ack_cycle && (state_q == RD_WAIT)) begin
            case (src_q)
                SRC_FETCH: if_rdata_q  <= bus.mem_rdata;
                SRC_DATA:  d_rdata_q   <= bus.mem_rdata;
`ifdef MEM_ARB_DMA_EN
                SRC_DMA:   dma_rdata_q <= bus.mem_rdata;
`endif
                default: ;
            endcase
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_is_write = is_write;
    assign bus.if_ack       = ack_cycle && (src_q == SRC_FETCH);
    assign bus.if_rdata     = if_rdata_q;
    assign bus.d_ack        = ack_cycle && (src_q == SRC_DATA);
    assign bus.d_rdata      = d_rdata_q;
`ifdef MEM_ARB_DMA_EN
    assign bus.dma_ack      = ack_cycle && (src_q == SRC_DMA);
    assign bus.dma_rdata    = dma_rdata_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed accesses, an access-level reference model
// checked every cycle, and literal expectations for the key scenarios.
module tb_mem_arbiter;
    localparam int RW = 1;
    localparam int SL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.READ_WAIT(RW), .STARVE_LIMIT(SL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic dma_req_v, dma_we_v, dma_ack_v;
    logic [31:0] dma_addr_v, dma_wdata_v, dma_rdata_v;
`ifdef MEM_ARB_DMA_EN
    assign dma_req_v   = bus.dma_req;
    assign dma_we_v    = bus.dma_we;
    assign dma_addr_v  = bus.dma_addr;
    assign dma_wdata_v = bus.dma_wdata;
    assign dma_ack_v   = bus.dma_ack;
    assign dma_rdata_v = bus.dma_rdata;
`else
    assign dma_req_v   = 1'b0;
    assign dma_we_v    = 1'b0;
    assign dma_addr_v  = '0;
    assign dma_wdata_v = '0;
    assign dma_ack_v   = 1'b0;
    assign dma_rdata_v = '0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Access-level model: one access at a time, aged in cycles since grant.
    bit          m_active = 1'b0;
    int          m_port   = 0;
    bit          m_write  = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    int          m_age    = 0;
    int          m_starve = 0;
    logic [31:0] m_rdata [3] = '{32'h0, 32'h0, 32'h0};

    always @(negedge clk) begin
        bit          ack_now;
        logic [2:0]  eack, aack;
        int          pick;
        if (chk_en) begin
            ack_now = m_active && !rst && !bus.mem_busy &&
                      (m_write ? (m_age >= 2) : (m_age >= RW + 1));
            eack = '0;
            if (ack_now) eack[m_port] = 1'b1;
            aack = {dma_ack_v, bus.d_ack, bus.if_ack};
            check32("acks", {29'd0, aack}, {29'd0, eack});
            check32("mem_is_write", {31'd0, bus.mem_is_write},
                    {31'd0, (m_active && m_write && m_age == 1)});
            check32("mem_addr", bus.mem_addr, m_addr);
            check32("mem_wdata", bus.mem_wdata, m_wdata);
            check32("if_rdata", bus.if_rdata, m_rdata[0]);
            check32("d_rdata", bus.d_rdata, m_rdata[1]);
            check32("dma_rdata", dma_rdata_v, m_rdata[2]);

            if (rst) begin
                m_active = 1'b0; m_port = 0; m_write = 1'b0;
                m_addr = '0; m_wdata = '0; m_age = 0; m_starve = 0;
                m_rdata = '{32'h0, 32'h0, 32'h0};
            end else begin
                if (!bus.if_req) m_starve = 0;
                if (m_active) begin
                    if (ack_now) begin
                        m_active = 1'b0;
                        if (!m_write) m_rdata[m_port] = bus.mem_rdata;
                    end else begin
                        m_age++;
                    end
                end else begin
                    pick = -1;
                    if (bus.if_req && m_starve == SL) pick = 0;
                    else if (bus.d_req)               pick = 1;
                    else if (dma_req_v)               pick = 2;
                    else if (bus.if_req)              pick = 0;
                    if (pick >= 0) begin
                        m_active = 1'b1;
                        m_port   = pick;
                        m_age    = 1;
                        case (pick)
                            0: begin m_write = 1'b0; m_addr = bus.if_addr; m_wdata = '0; end
                            1: begin m_write = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata; end
                            default: begin m_write = dma_we_v; m_addr = dma_addr_v; m_wdata = dma_wdata_v; end
                        endcase
                        if (bus.if_req) begin
                            if (pick == 0)          m_starve = 0;
                            else if (m_starve < SL) m_starve++;
                        end
                    end
                end
            end
        end
    end

    function automatic logic ack_of(input int p);
        case (p)
            0:       return bus.if_ack;
            1:       return bus.d_ack;
            default: return dma_ack_v;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int p, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ack_of(p)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout port=%0d: got no ack, required one within %0d cycles", p, limit);
        end
    endtask

    // Hold both requests until fetch is acked; returns data acks seen and timing.
    task automatic run_starve(output int dc, output int last_d, output int at_f);
        bit done;
        dc = 0; last_d = -1; at_f = -1; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bus.d_ack) begin dc++; last_d = cyc; end
            if (bus.if_ack) begin done = 1'b1; at_f = cyc; end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL starve_timeout: got no if_ack, required one within 300 cycles");
        end
    endtask

    initial begin
        int g, at, at_d, at_f, dc, last_d, pulses, pc;
        logic [31:0] pa, pd;
        bit done;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_busy = 0;
`ifdef MEM_ARB_DMA_EN
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
`endif
        repeat (3) tick();
        chk_en = 1'b1;
        @(negedge clk);
        check32("rst_is_write", {31'd0, bus.mem_is_write}, 32'd0);
        check32("rst_acks", {29'd0, dma_ack_v, bus.d_ack, bus.if_ack}, 32'd0);
        check32("rst_mem_addr", bus.mem_addr, 32'h0);
        check32("rst_if_rdata", bus.if_rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Lone fetch read: ack two cycles after grant.
        bus.mem_rdata = 32'h1234_5678; bus.if_addr = 32'h0000_0100; bus.if_req = 1;
        g = cyc;
        wait_ack(0, 20, at);
        check32("fetch_latency", at - g, 32'd2);
        check32("fetch_mem_addr", bus.mem_addr, 32'h0000_0100);
        tick();
        bus.if_req = 0;
        @(negedge clk);
        check32("fetch_rdata", bus.if_rdata, 32'h1234_5678);
        tick();

        // Simultaneous fetch and data reads: data first, fetch right after.
        bus.mem_rdata = 32'hA5A5_0001;
        bus.if_addr = 32'h0000_0300; bus.if_req = 1;
        bus.d_we = 0; bus.d_addr = 32'h0000_0400; bus.d_req = 1;
        g = cyc;
        wait_ack(1, 20, at_d);
        check32("data_first_latency", at_d - g, 32'd2);
        tick();
        bus.d_req = 0;
        wait_ack(0, 20, at_f);
        check32("fetch_after_data", at_f - at_d, 32'd3);
        tick();
        bus.if_req = 0;
        @(negedge clk);
        check32("both_d_rdata", bus.d_rdata, 32'hA5A5_0001);
        tick();

        // Data write with busy controller; one strobe, ack after busy falls.
        bus.d_we = 1; bus.d_addr = 32'h0000_0200; bus.d_wdata = 32'hDEAD_BEEF; bus.d_req = 1;
        g = cyc; pulses = 0; pc = -1; pa = '0; pd = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.mem_busy = 1;
            @(negedge clk);
            if (bus.mem_is_write) begin pulses++; pc = cyc; pa = bus.mem_addr; pd = bus.mem_wdata; end
        end
        tick();
        bus.mem_busy = 0;
        wait_ack(1, 10, at);
        check32("wr_pulses", pulses, 32'd1);
        check32("wr_pulse_cycle", pc - g, 32'd1);
        check32("wr_addr", pa, 32'h0000_0200);
        check32("wr_data", pd, 32'hDEAD_BEEF);
        check32("wr_ack_cycle", at - g, 32'd5);
        check32("wr_keeps_rdata", bus.d_rdata, 32'hA5A5_0001);
        tick();
        bus.d_req = 0; bus.d_we = 0;
        tick();

        // Starvation: fetch wins after exactly SL data grants.
        bus.mem_rdata = 32'h0000_D000;
        bus.if_addr = 32'h0000_0500; bus.if_req = 1;
        bus.d_addr = 32'h0000_0600; bus.d_req = 1;
        run_starve(dc, last_d, at_f);
        check32("starve_data_grants", dc, 32'd8);
        check32("starve_fetch_slot", at_f - last_d, 32'd3);
        tick();
        bus.if_req = 0; bus.d_req = 0;
        tick();

        // Starve count clears when fetch drops its request before a grant.
        bus.if_req = 1; bus.d_req = 1;
        dc = 0; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.d_ack) dc++;
            if (dc == 5) done = 1'b1;
        end
        check32("clear_pre_acks", dc, 32'd5);
        tick();
        bus.if_req = 0;
        tick();
        bus.if_req = 1;
        run_starve(dc, last_d, at_f);
        check32("clear_data_grants", dc, 32'd9);
        tick();
        bus.if_req = 0; bus.d_req = 0;
        tick();

        // Reset during WR_WAIT abandons the write.
        at_d = 0;
        bus.d_we = 1; bus.d_addr = 32'h0000_0700; bus.d_wdata = 32'h1111_2222; bus.d_req = 1;
        tick();
        bus.mem_busy = 1;
        @(negedge clk);
        if (bus.d_ack) at_d++;
        tick();
        @(negedge clk);
        if (bus.d_ack) at_d++;
        tick();
        rst = 1;
        @(negedge clk);
        if (bus.d_ack) at_d++;
        tick();
        rst = 0; bus.mem_busy = 0; bus.d_req = 0;
        @(negedge clk);
        if (bus.d_ack) at_d++;
        check32("rst_no_ack", at_d, 32'd0);
        check32("rst_wr_low", {31'd0, bus.mem_is_write}, 32'd0);
        check32("rst_addr_clear", bus.mem_addr, 32'h0);
        check32("rst_d_rdata", bus.d_rdata, 32'h0);
        tick();
        bus.d_addr = 32'h0000_0800; bus.d_wdata = 32'h3333_4444; bus.d_req = 1;
        g = cyc;
        wait_ack(1, 20, at);
        check32("post_rst_write", at - g, 32'd2);
        tick();
        bus.d_req = 0; bus.d_we = 0;
        tick();

`ifdef MEM_ARB_DMA_EN
        // DMA beats fetch when raised together.
        bus.mem_rdata = 32'hCAFE_0001;
        bus.dma_we = 0; bus.dma_addr = 32'h0000_0900; bus.dma_req = 1;
        bus.if_addr = 32'h0000_0A00; bus.if_req = 1;
        g = cyc;
        wait_ack(2, 20, at_d);
        check32("dma_first", at_d - g, 32'd2);
        tick();
        bus.dma_req = 0;
        wait_ack(0, 20, at_f);
        check32("fetch_after_dma", at_f - at_d, 32'd3);
        tick();
        bus.if_req = 0;
        @(negedge clk);
        check32("dma_rdata_val", bus.dma_rdata, 32'hCAFE_0001);
        tick();
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter READ_WAIT, default 1: cycles the address is held before read data is sampled (1..15).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive lost arbitrations after which the fetch port is forced to win (1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have ports if_req  input  1, if_addr  input  32, if_ack  output  1, if_rdata  output  32: read-only instruction-fetch port.
REQ-006 SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  32, d_wdata  input  32, d_ack  output  1, d_rdata  output  32: CPU data port.
REQ-007 SHALL have ports dma_req  input  1, dma_we  input  1, dma_addr  input  32, dma_wdata  input  32, dma_ack  output  1, dma_rdata  output  32: DMA port; present only under MEM_ARB_DMA_EN.
REQ-008 SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_is_write  output  1, mem_rdata  input  32, mem_busy  input  1: physical memory controller side.

Function
REQ-009 FSM states: IDLE, RD_WAIT, WR_PULSE, WR_WAIT; reset state IDLE.
REQ-010 IDLE: if any req high, grant one; read grant -> RD_WAIT with wait counter = READ_WAIT; write grant -> WR_PULSE.
REQ-011 Priority: data > DMA > fetch, except fetch wins when its starve counter equals STARVE_LIMIT.
REQ-012 Starve counter: +1 each grant to another port while if_req is high; cleared on fetch grant or if_req low; saturates at STARVE_LIMIT.
REQ-013 Granted port's address/wdata/we are latched at grant; mem_addr/mem_wdata driven from the latch until return to IDLE; requester changes after grant are ignored.
REQ-014 mem_is_write SHALL be 0 in all states except WR_PULSE, where it is 1 for exactly one cycle.
REQ-015 RD_WAIT: counter decrements each cycle; when counter is 0 and mem_busy is 0, mem_rdata is captured into the granted port's rdata, its ack pulses 1 cycle, FSM -> IDLE.
REQ-016 WR_PULSE -> WR_WAIT unconditionally; WR_WAIT: first cycle with mem_busy 0 after entry (earliest the cycle after WR_PULSE) pulses ack and -> IDLE.
REQ-017 Read latency from grant to ack: READ_WAIT+1 cycles with mem_busy low; write: at least 2 cycles plus controller busy time.
REQ-018 Each ack is a single-cycle pulse; at most one ack asserted per cycle.
REQ-019 Each rdata output holds its last captured value until that port's next read ack; writes do not alter rdata.
REQ-020 Requesters hold req until ack; req must drop in the ack cycle; a req dropped before grant causes no access.
REQ-021 No new grant in the ack cycle; next grant earliest the cycle after ack (one idle cycle between accesses).
REQ-022 Requests arriving while not IDLE wait; simultaneous requests resolved per REQ-011 in IDLE only.
REQ-023 Fetch port never asserts mem_is_write.

Reset
REQ-024 rst high: FSM -> IDLE, mem_is_write 0, all acks 0, starve counter 0, wait counter 0, address/wdata latches and all rdata outputs 0.
REQ-025 rst mid-access abandons the access with no ack; mem_is_write deasserts the cycle after rst is sampled.

Configuration
REQ-026 Macro MEM_ARB_DMA_EN defined: DMA port present and arbitrated per REQ-011.
REQ-027 MEM_ARB_DMA_EN undefined: DMA ports absent, priority data > fetch, starvation rule unchanged.

Verification
REQ-028 Only if_req, addr 0x00000100, mem_rdata 0x12345678, busy 0, READ_WAIT 1 -> if_ack pulses 2 cycles after grant, if_rdata 0x12345678.
REQ-029 d_req write, addr 0x00000200, data 0xDEADBEEF -> mem_is_write high exactly 1 cycle with mem_addr 0x00000200, mem_wdata 0xDEADBEEF; d_ack after mem_busy falls.
REQ-030 if_req and d_req (read) raised same cycle -> data granted first, fetch granted the cycle after d_ack.
REQ-031 d_req re-asserted continuously with if_req held, STARVE_LIMIT 8 -> fetch granted after exactly 8 data grants.
REQ-032 rst asserted in WR_WAIT -> no d_ack, mem_is_write 0, FSM IDLE; next d_req served normally.
REQ-033 With MEM_ARB_DMA_EN, dma_req and if_req same cycle -> DMA granted first; without macro, build has no dma_* ports.
